uart_rx: RTL
============

Name: uart_rx

Overview:
- UART receiver: recovers 8N1 serial frames from the `rx` line using the 16x-baud sample-enable tick produced by the design's baud generator.
- Presents each received byte with a one-clock valid strobe. Flags framing errors.
- Sits between the board RX pin and the AES command/data front end. The tick is an enable, never a clock.

Parameters:
- DATA_BITS, 8, data bits per frame, LSB first.
- OVERSAMPLE, 16, s_tick pulses per bit period; must be even, at least 4.
- SYNC_STAGES, 2, flip-flop stages on rx before use.

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- s_tick  input  1  sample enable, one clk wide, 16x baud rate.
- rx  input  1  asynchronous serial line, idle high.
- rx_data  output  DATA_BITS  last correctly received byte; held until the next valid frame.
- rx_valid  output  1  one-clk pulse; rx_data is new this cycle.
- frame_err  output  1  one-clk pulse; stop bit sampled low, byte discarded.

Behaviour:
- Reset values (while reset=1 at a clk edge):
  - state=IDLE; tick counter=0; bit counter=0; shift register=0.
  - All synchronizer stages=1; prev-sample=1.
  - rx_data=0, rx_valid=0, frame_err=0.
  - Reset wins over every other event, including mid-frame.
- Synchronizer: rx passes through SYNC_STAGES flops. rxs is the last stage. Every use of "rx" below means rxs.
- Counters and transitions advance only in cycles where s_tick=1. With s_tick=0 everything holds, except that rx_valid and frame_err fall to 0.
- Tick counter width is clog2(OVERSAMPLE). Bit counter width is clog2(DATA_BITS+1).
- IDLE:
  - On a tick, latch prev=rxs.
  - If prev=1 and rxs=0 (falling edge seen on tick sampling): go to START and clear the tick counter.
  - Edge detection means a line held low (break) cannot retrigger a frame.
- START:
  - Count ticks. At counter=OVERSAMPLE/2-1 (mid start bit), sample rx.
  - rx=0: go to DATA, clear the tick counter and bit counter.
  - rx=1: false start; go to IDLE with prev=1. No output.
- DATA:
  - At counter=OVERSAMPLE-1 (mid bit), shift rx into the shift register MSB side (shift right, so the first bit ends at bit 0).
  - Increment the bit counter and clear the tick counter.
  - After DATA_BITS samples, go to STOP.
- STOP: at counter=OVERSAMPLE-1, sample rx.
  - rx=1: rx_data<=shift register; rx_valid=1 for the next clk only.
  - rx=0: frame_err=1 for the next clk only; rx_data unchanged; prev<=0.
  - Either way, go to IDLE. Counters are cleared.
- Outputs are registered. Strobe latency is one clk after the stop-bit sampling tick edge. Frame end to strobe is mid stop bit, giving half a bit of slack for back-to-back frames.
- rx_valid and frame_err are never both 1. Each fires at most once per frame.
- A start edge arriving on the tick right after STOP→IDLE is accepted. Back-to-back frames with zero idle gap must be received.
- Glitches shorter than OVERSAMPLE/2 ticks on the start bit are rejected. Data bits are single-sampled; there is no majority vote.

Decomposition:
- Shared package uart_pkg holds:
  - state enum {IDLE, START, DATA, STOP}, 2 bits;
  - default constants UART_DATA_BITS=8 and UART_OVERSAMPLE=16, also reused by the transmitter.
- One sub-module: uart_sync, a SYNC_STAGES-deep synchronizer with reset value 1.
- FSM, counters and shift register stay in uart_rx.

Test Plan:
- Drive 0xA5 at 16 ticks/bit (s_tick every 4 clk) -> exactly one rx_valid pulse, rx_data=0xA5, frame_err never 1.
- Send 0x00 then 0xFF with no idle between frames -> two rx_valid pulses, rx_data 0x00 then 0xFF.
- Drop rx low for 5 ticks, then return it high -> FSM returns to IDLE, no rx_valid, no frame_err. A following 0x3C frame is received correctly.
- Send 0x5A with the stop bit low, then hold rx low for 40 bit times -> one frame_err pulse, rx_data keeps its previous value, no further strobes. After rx goes high, 0x81 is received.
- Assert reset for 1 clk after the 3rd data bit of a frame -> all outputs 0 the next cycle, no strobe for the aborted frame. The next 0xC3 frame is received correctly.
- Hold s_tick=0 mid-frame for 100 clk -> state and counters frozen. The frame completes correctly once ticks resume.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and default frame geometry.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS  = 8;
  localparam int unsigned UART_OVERSAMPLE = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/uart_sync.sv
// Multi-stage synchronizer for an asynchronous input; resets to the idle-high level.
module uart_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] stage_q;

  // Shift the raw input through the chain; stage 0 is the only one that can go metastable.
  always_ff @(posedge clk) begin
    if (reset) begin
      stage_q <= '1;
    end else begin
      stage_q[0] <= d;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver driven by a 16x-baud sample enable; strobes each byte or a framing error.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS   = UART_DATA_BITS,
  parameter int unsigned OVERSAMPLE  = UART_OVERSAMPLE,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err
);

  localparam int unsigned TickW = $clog2(OVERSAMPLE);
  localparam int unsigned BitW  = $clog2(DATA_BITS + 1);

  localparam logic [TickW-1:0] TickMid  = TickW'(OVERSAMPLE / 2 - 1);
  localparam logic [TickW-1:0] TickLast = TickW'(OVERSAMPLE - 1);
  localparam logic [BitW-1:0]  BitLast  = BitW'(DATA_BITS - 1);

  logic                 rxs;
  uart_state_e          state_q;
  logic [TickW-1:0]     tick_cnt_q;
  logic [BitW-1:0]      bit_cnt_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 prev_q;

  uart_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (rx),
    .q    (rxs)
  );

  // Frame FSM: everything advances only on s_tick; the strobes are one clk wide regardless.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      prev_q     <= 1'b1;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      if (s_tick) begin
        unique case (state_q)
          IDLE: begin
            prev_q <= rxs;
            // Edge, not level: a held-low line (break) never starts a frame.
            if (prev_q && !rxs) begin
              state_q    <= START;
              tick_cnt_q <= '0;
            end
          end
          START: begin
            if (tick_cnt_q == TickMid) begin
              tick_cnt_q <= '0;
              if (!rxs) begin
                state_q   <= DATA;
                bit_cnt_q <= '0;
              end else begin
                // Glitch shorter than half a bit: drop it silently.
                state_q <= IDLE;
                prev_q  <= 1'b1;
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + TickW'(1);
            end
          end
          DATA: begin
            if (tick_cnt_q == TickLast) begin
              tick_cnt_q <= '0;
              shift_q    <= {rxs, shift_q[DATA_BITS-1:1]};
              bit_cnt_q  <= bit_cnt_q + BitW'(1);
              if (bit_cnt_q == BitLast) begin
                state_q <= STOP;
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + TickW'(1);
            end
          end
          STOP: begin
            if (tick_cnt_q == TickLast) begin
              state_q    <= IDLE;
              tick_cnt_q <= '0;
              bit_cnt_q  <= '0;
              // A good stop leaves prev high so a start edge on the very next tick is caught.
              prev_q     <= rxs;
              if (rxs) begin
                rx_data  <= shift_q;
                rx_valid <= 1'b1;
              end else begin
                frame_err <= 1'b1;
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + TickW'(1);
            end
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
